serial_equaln: RTL and testbench
================================

SERIAL_EQUALN -- requirements
Module: serial_equaln

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH are required; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request presents a/b.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have ports a and b, input, WIDTH each, the operands.
REQ-008 SHALL have port flush, input, 1, synchronous abort of any request held in the block.
REQ-009 SHALL have port out_valid, output, 1, result is available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port eq, output, 1, 1 when a == b over all WIDTH bits.
REQ-012 SHALL have port mismatch_idx, output, max(1,clog2(NCH)), lowest-numbered differing chunk (chunk i = bits [i*CHUNK+CHUNK-1 : i*CHUNK]).
REQ-013 SHALL have port busy, output, 1, high in CMP or DONE.

Function
REQ-014 SHALL implement states IDLE, CMP and DONE.
REQ-015 In IDLE: in_ready=1; in_valid=1 latches a and b, clears chunk index idx to 0, next state CMP.
REQ-016 In CMP, each edge compares latched chunk idx: on mismatch go to DONE with eq=0 and mismatch_idx=idx; on match with idx==NCH-1 go to DONE with eq=1 and mismatch_idx=0; otherwise idx increments.
REQ-017 Latency: out_valid rises k edges after the accept edge, k = chunks examined (1..NCH); equal operands take exactly NCH.
REQ-018 In DONE: out_valid=1; eq and mismatch_idx stay stable until out_valid=1 and out_ready=1 on the same edge, then next state IDLE.
REQ-019 in_ready SHALL be 0 in CMP and DONE; in_valid there is ignored and changes to a/b do not affect the result in progress.
REQ-020 One bubble minimum between requests: DONE->IDLE, then accept in IDLE.
REQ-021 flush=1 forces IDLE on the next edge from any state, discards latched data and produces no out_valid; flush has priority over in_valid and out_ready on the same edge.
REQ-022 If NCH == 1, CMP SHALL last exactly one cycle.
REQ-023 eq and mismatch_idx SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, idx=0, latched operands=0, out_valid=0, eq=0, mismatch_idx=0 and busy=0; in_ready=1 follows from IDLE.
REQ-025 rst asserted mid-CMP or mid-DONE SHALL drop the request with no out_valid; first edge after deassertion behaves as IDLE.

Structure
REQ-026 State encodings (IDLE=2'd0, CMP=2'd1, DONE=2'd2) SHALL be localparams in the shared nbitdevices package/include; 2'd3 SHALL recover to IDLE.
REQ-027 The per-chunk compare SHALL instantiate the existing equaln sub-module with WIDTH=CHUNK on the idx-selected slices of the latched operands.

Verification (WIDTH=32, CHUNK=8, out_ready=1 unless stated)
REQ-028 a=b=32'hDEADBEEF -> out_valid 4 edges after accept, eq=1, mismatch_idx=0.
REQ-029 a=32'h000000FF, b=32'h000000FE -> out_valid 1 edge after accept, eq=0, mismatch_idx=0.
REQ-030 a=32'h12345678, b=32'h92345678 -> out_valid after 4 edges, eq=0, mismatch_idx=3.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new a/b -> eq and mismatch_idx stable, in_ready=0, new request not accepted; IDLE one edge after out_ready=1.
REQ-032 Assert rst for 1 cycle two edges after accepting a=b=0 -> all outputs at reset values at once, no out_valid; a=1, b=1 next completes with eq=1 after 4 edges.
REQ-033 flush=1 and in_valid=1 on the same edge during CMP -> IDLE next edge, no out_valid, request not latched; the following request completes normally.

Source files
------------

// File: rtl/serial_equaln_pkg.sv
// Shared definitions for the serial chunk-wise equality comparator.
// State encodings, FSM type and index-width helper.
package serial_equaln_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMP  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CMP  = ST_CMP,
      DONE = ST_DONE
   } state_e;

   function automatic int idx_w(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

endpackage

// File: rtl/serial_equaln_if.sv
// Request/result handshake bundle for serial_equaln.
// The master side issues operands and consumes the result.
interface serial_equaln_if
   import serial_equaln_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) ();

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = idx_w(NCH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             eq;
   logic [IW-1:0]    mismatch_idx;
   logic             busy;

   modport master (
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output flush,
      input  out_valid,
      output out_ready,
      input  eq,
      input  mismatch_idx,
      input  busy
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  flush,
      output out_valid,
      input  out_ready,
      output eq,
      output mismatch_idx,
      output busy
   );

endinterface

// File: rtl/equaln.sv
// Combinational N-bit equality compare.
module equaln #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq
);

   assign eq = (a == b);

endmodule

// File: rtl/serial_equaln.sv
// Multi-cycle equality compare, CHUNK bits per cycle, lowest chunk first.
// Stops at the first differing chunk and reports its index.
module serial_equaln
   import serial_equaln_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic           clk,
   input logic           rst,
   serial_equaln_if.slave bus
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = idx_w(NCH);
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             eq_q, eq_d;
   logic [IW-1:0]    mis_q, mis_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic             chunk_eq;

   assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
   assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

   equaln #(
      .WIDTH (CHUNK)
   ) u_equaln (
      .a  (a_chunk),
      .b  (b_chunk),
      .eq (chunk_eq)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      eq_d    = eq_q;
      mis_d   = mis_q;
      if (bus.flush) begin
         state_d = IDLE;
         idx_d   = '0;
         a_d     = '0;
         b_d     = '0;
         eq_d    = 1'b0;
         mis_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_d     = bus.a;
                  b_d     = bus.b;
                  idx_d   = '0;
                  state_d = CMP;
               end
            end
            CMP: begin
               if (!chunk_eq) begin
                  state_d = DONE;
                  eq_d    = 1'b0;
                  mis_d   = idx_q;
               end else if (idx_q == LAST) begin
                  state_d = DONE;
                  eq_d    = 1'b1;
                  mis_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d = IDLE;
                  eq_d    = 1'b0;
                  mis_d   = '0;
               end
            end
            // Unused encoding 2'd3 falls back to IDLE.
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               eq_d    = 1'b0;
               mis_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         eq_q    <= 1'b0;
         mis_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         eq_q    <= eq_d;
         mis_q   <= mis_d;
      end
   end

   // Result outputs are gated so they read zero outside DONE.
   assign bus.in_ready     = (state_q == IDLE);
   assign bus.out_valid    = (state_q == DONE);
   assign bus.busy         = (state_q == CMP) || (state_q == DONE);
   assign bus.eq           = bus.out_valid & eq_q;
   assign bus.mismatch_idx = bus.out_valid ? mis_q : '0;

endmodule

// File: tb/tb_serial_equaln.sv
// Bench for serial_equaln: vector table plus handshake, reset and flush sequences.
module tb_serial_equaln;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   serial_equaln_if #(.WIDTH(32), .CHUNK(8)) bus ();

   serial_equaln #(
      .WIDTH (32),
      .CHUNK (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       eq;
      logic [1:0] idx;
      int         lat;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        eq;
      logic [1:0]  idx;
      int          lat;
   } vec_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_req(input logic [31:0] ta, input logic [31:0] tb_v,
                          input exp_t e);
      int   lat;
      exp_t got;
      sb.push_back(e);
      bus.a        = ta;
      bus.b        = tb_v;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      got = sb.pop_front();
      chk("latency", 32'(lat), 32'(got.lat));
      chk("eq", 32'(bus.eq), 32'(got.eq));
      chk("mismatch_idx", 32'(bus.mismatch_idx), 32'(got.idx));
   endtask

   task automatic retire();
      @(posedge clk); #1;
      chk("retire_in_ready", 32'(bus.in_ready), 32'd1);
      chk("retire_out_valid", 32'(bus.out_valid), 32'd0);
      chk("retire_eq", 32'(bus.eq), 32'd0);
   endtask

   task automatic watch_idle(input string name, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         seen = seen | bus.out_valid | bus.busy;
      end
      chk(name, 32'(seen), 32'd0);
   endtask

   vec_t vecs[7];

   initial begin
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;

      vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 2'd0, 4};
      vecs[1] = '{32'h000000FF, 32'h000000FE, 1'b0, 2'd0, 1};
      vecs[2] = '{32'h12345678, 32'h92345678, 1'b0, 2'd3, 4};
      vecs[3] = '{32'h00FF0000, 32'h00FE0000, 1'b0, 2'd2, 3};
      vecs[4] = '{32'h0000AB00, 32'h00000000, 1'b0, 2'd1, 2};
      vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2'd0, 4};
      vecs[6] = '{32'h80000001, 32'h00000001, 1'b0, 2'd3, 4};

      #2;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_eq", 32'(bus.eq), 32'd0);
      chk("rst_idx", 32'(bus.mismatch_idx), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_req(vecs[i].a, vecs[i].b,
                 '{vecs[i].eq, vecs[i].idx, vecs[i].lat});
         retire();
      end

      // Result held while consumer stalls; new requests ignored.
      bus.out_ready = 1'b0;
      run_req(32'h00010000, 32'h00000000, '{1'b0, 2'd2, 3});
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = $urandom;
         bus.b        = $urandom;
         @(posedge clk); #1;
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_eq", 32'(bus.eq), 32'd0);
         chk("stall_idx", 32'(bus.mismatch_idx), 32'd2);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
      chk("stall_release_busy", 32'(bus.busy), 32'd0);
      watch_idle("stall_no_new_req", 3);

      // Reset in the middle of a compare.
      bus.a        = 32'h0;
      bus.b        = 32'h0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_eq", 32'(bus.eq), 32'd0);
      chk("midrst_idx", 32'(bus.mismatch_idx), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      watch_idle("midrst_no_out_valid", 6);
      run_req(32'h1, 32'h1, '{1'b1, 2'd0, 4});
      retire();

      // Flush beats a simultaneous in_valid during CMP.
      bus.a        = 32'h5;
      bus.b        = 32'h5;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush    = 1'b1;
      bus.a        = 32'h7;
      bus.b        = 32'h9;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
      chk("flush_busy", 32'(bus.busy), 32'd0);
      watch_idle("flush_no_out_valid", 6);
      run_req(32'h00000100, 32'h00000000, '{1'b0, 2'd1, 2});
      retire();

      // Flush while a result is held.
      bus.out_ready = 1'b0;
      run_req(32'h3, 32'h3, '{1'b1, 2'd0, 4});
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      chk("dflush_out_valid", 32'(bus.out_valid), 32'd0);
      chk("dflush_eq", 32'(bus.eq), 32'd0);
      chk("dflush_in_ready", 32'(bus.in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
